write_rw: RTL and testbench
===========================

# write_rw

Write-back stage of the per-tile read-write pipeline. It takes `rw_write_t` entries produced by the RW read stage and modified by the core: thread, CQ slot, task descriptor and updated 32-bit object. It issues a single-word AXI write (AW/W/B) of the object back to the tile's RW memory and reports task completion to the task unit once the write is acknowledged. Tasks with `no_write` set bypass memory and complete directly.

## Interface
Parameters:
- `TILE_ID`, 0, tile index, used for debug display only.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `task_in_valid`  in  1  input entry valid.
- `task_in_ready`  out  1  input entry accepted this cycle.
- `task_in`  in  `rw_write_t`  task_desc, cq_slot, thread, object, cache_addr.
- `awvalid`  out  1  write address valid.
- `awready`  in  1  write address accepted.
- `awaddr`  out  32  byte address.
- `awid`  out  `id_t`  equals the thread id.
- `wvalid`  out  1  write data valid.
- `wready`  in  1  write data accepted.
- `wdata`  out  512  object replicated 16 times.
- `wstrb`  out  64  byte enables.
- `bvalid`  in  1  write response valid.
- `bready`  out  1  write response accepted.
- `bid`  in  `id_t`  thread id of the completing write.
- `finish_valid`  out  1  task completion valid.
- `finish_ready`  in  1  task unit accepts the completion.
- `finish_thread`  out  `thread_id_t`  thread id of the completing task.
- `finish_cq_slot`  out  `cq_slice_slot_t`  CQ slot of the completing task.
- `reg_bus`  `reg_bus_t`  register access port.

## Operation
- `awaddr` = `base_rw_addr + (task_desc.locale << RW_ARSIZE)`, truncated to 32 bits.
- `wstrb` = `64'hF << (locale[3:0]*4)`. `wdata` = `{16{object}}`.
- Input holding register `cur` with flags `aw_done` and `w_done`.
  - `task_in_ready` = `!cur_valid | (aw/w both done or about to be done this cycle)`, and `outstanding < N_THREADS`.
  - A `no_write` entry goes to bypass register `byp` instead of `cur`. It is accepted only when `byp` is empty or draining this cycle.
- `awvalid` = `cur_valid & !aw_done`. `wvalid` = `cur_valid & !w_done`. The two channels are independent and either may complete first.
- On AW accept, per-thread tables `slot_tbl[thread]` and `ts_tbl` are written.
- `outstanding`: +1 on AW handshake, −1 on B handshake. Simultaneous events net to 0.
- Finish arbitration: B response has priority over `byp`.
  - `bready` = `finish_ready`.
  - With `bvalid`: `finish_valid`=1, thread=`bid`, slot=`slot_tbl[bid]`.
  - Otherwise a valid `byp` drives finish.
- `bresp` is ignored.
- Registers:
  - Write `RW_BASE_ADDR`: `base_rw_addr = {wdata[29:0],2'b00}`.
  - Read `DEBUG_CAPACITY` returns `outstanding`.
  - Read `CORE_N_DEQUEUES` returns the completed-task count (32-bit, wraps).
  - `rvalid` is asserted one cycle after `arvalid`.

## Timing
- Reset: `cur_valid`, `byp_valid`, `aw_done`, `w_done` = 0. `outstanding`, `base_rw_addr`, completed count = 0. All valid outputs = 0. `reg_bus.rvalid` = 0.
- Input to AW/W valid: 1 cycle (registered).
- B to finish: combinational (0 cycles).
- `no_write` input to finish: 1 cycle.
- Valid signals never drop without a handshake. AW/W payloads stay stable while valid.
- Reset mid-transfer drops all state. Outstanding B responses after reset are undefined behaviour for the system; the block makes no guarantee for them.

## Structure
- `rw_write_t`, `id_t`, `thread_id_t`, `cq_slice_slot_t`, `RW_ARSIZE`, `N_THREADS`, and the register addresses are taken from package `swarm`. No new package entries.
- Single module, no sub-module.
- `slot_tbl` is an N_THREADS-deep distributed RAM: one write port, one async read port.

## Test plan
- Write, locale=5, base=0x1000, object=0xDEADBEEF, thread 3, slot 7:
  - awaddr = 0x1000+(5<<RW_ARSIZE), wstrb=0x0000_0000_00F0_0000 for the 4 bytes at 20..23.
  - bid=3 produces finish thread=3, slot=7.
- W accepted 3 cycles before AW: one AW, one W issued. Next input accepted only after both handshakes complete.
- `no_write` task (thread 2) while bvalid is held with finish_ready=1:
  - B completes first.
  - Bypass task finishes the following cycle.
  - No AW/W issued for thread 2.
- finish_ready=0 for 10 cycles with bvalid=1:
  - bready stays 0.
  - finish holds the same thread/slot until ready.
- N_THREADS writes issued with no B: task_in_ready=0. One B returns, then one further input is accepted.
- Reset asserted with `cur_valid` and 2 outstanding:
  - All valid outputs are 0 the cycle after.
  - `outstanding` reads 0 through `DEBUG_CAPACITY`.

Source files
------------

// File: rtl/swarm_pkg.sv
// Shared tile-level types and constants for the read-write pipeline.
//   N_THREADS       : number of hardware threads per tile
//   RW_ARSIZE       : log2 of the RW object size in bytes
//   rw_write_t      : entry handed from the RW read stage / core to write-back
//   register map    : addresses decoded on the tile register bus
package swarm;

    localparam int N_THREADS = 8;
    localparam int THREAD_W  = $clog2(N_THREADS);
    localparam int RW_ARSIZE = 2;

    localparam logic [15:0] RW_BASE_ADDR    = 16'h0040;
    localparam logic [15:0] DEBUG_CAPACITY  = 16'h0044;
    localparam logic [15:0] CORE_N_DEQUEUES = 16'h0048;

    typedef logic [THREAD_W-1:0] thread_id_t;
    typedef logic [THREAD_W-1:0] id_t;
    typedef logic [3:0]          cq_slice_slot_t;

    typedef struct packed {
        logic [31:0] ts;
        logic [31:0] locale;
        logic        no_write;
    } task_t;

    typedef struct packed {
        task_t          task_desc;
        cq_slice_slot_t cq_slot;
        thread_id_t     thread;
        logic [31:0]    object;
        logic [31:0]    cache_addr;
    } rw_write_t;

endpackage

// File: rtl/reg_bus_t.sv
// Tile register bus. Writes take effect on the cycle wvalid is sampled;
// a read request on arvalid is answered with rvalid/rdata one cycle later.
//   wvalid/waddr/wdata   : single-cycle register write
//   arvalid/araddr       : single-cycle read request
//   rvalid/rdata         : read response
interface reg_bus_t;
    logic        wvalid;
    logic [15:0] waddr;
    logic [31:0] wdata;
    logic        arvalid;
    logic [15:0] araddr;
    logic        rvalid;
    logic [31:0] rdata;

    modport slave  (input wvalid, waddr, wdata, arvalid, araddr, output rvalid, rdata);
    modport master (output wvalid, waddr, wdata, arvalid, araddr, input rvalid, rdata);
endinterface

// File: rtl/write_rw.sv
// Write-back stage of the tile read-write pipeline.
// Accepts modified RW objects, writes each one back with a single-beat AXI
// write, and reports task completion once the write response returns.
// Tasks flagged no_write skip memory and complete through a bypass register.
//   clk, rstn           : clock, synchronous active-low reset
//   task_in_*           : entry from the core (valid/ready)
//   aw*, w*, b*         : AXI write channels towards RW memory
//   finish_*            : completion report to the task unit
//   reg_bus             : base address config, debug/statistics readback
module write_rw
    import swarm::*;
#(
    parameter int TILE_ID = 0
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           task_in_valid,
    output logic           task_in_ready,
    input  rw_write_t      task_in,
    output logic           awvalid,
    input  logic           awready,
    output logic [31:0]    awaddr,
    output id_t            awid,
    output logic           wvalid,
    input  logic           wready,
    output logic [511:0]   wdata,
    output logic [63:0]    wstrb,
    input  logic           bvalid,
    output logic           bready,
    input  id_t            bid,
    output logic           finish_valid,
    input  logic           finish_ready,
    output thread_id_t     finish_thread,
    output cq_slice_slot_t finish_cq_slot,
    reg_bus_t.slave        reg_bus
);

    // Wide enough to count past N_THREADS without wrapping.
    localparam int CNT_W = THREAD_W + 2;

    rw_write_t      cur_q;
    logic           cur_valid_q;
    logic           aw_done_q;
    logic           w_done_q;
    logic [31:0]    awaddr_q;

    logic           byp_valid_q;
    thread_id_t     byp_thread_q;
    cq_slice_slot_t byp_slot_q;

    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [31:0]      base_rw_addr_q;
    logic [31:0]      n_done_q;
    logic             rvalid_q;
    logic [31:0]      rdata_q, rdata_d;

    cq_slice_slot_t slot_tbl [N_THREADS];
    logic [31:0]    ts_tbl   [N_THREADS];

    logic aw_hs, w_hs, b_hs, fin_hs;
    logic cur_drain, cur_free, below_cap;
    logic byp_drain, byp_free;
    logic acc_write, acc_byp;

    assign awvalid = cur_valid_q & ~aw_done_q;
    assign wvalid  = cur_valid_q & ~w_done_q;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;

    assign awaddr = awaddr_q;
    assign awid   = cur_q.thread;
    assign wdata  = {16{cur_q.object}};
    assign wstrb  = 64'hF << {cur_q.task_desc.locale[3:0], 2'b00};

    // The holding register frees up in the same cycle its last channel
    // handshakes, so back-to-back entries need no bubble.
    assign cur_drain = cur_valid_q & (aw_done_q | awready) & (w_done_q | wready);
    assign cur_free  = ~cur_valid_q | cur_drain;
    assign below_cap = outstanding_q < CNT_W'(N_THREADS);

    // B responses always win the finish port; bypass drains only when idle.
    assign bready    = finish_ready;
    assign b_hs      = bvalid & finish_ready;
    assign byp_drain = byp_valid_q & ~bvalid & finish_ready;
    assign byp_free  = ~byp_valid_q | byp_drain;

    assign task_in_ready = task_in.task_desc.no_write ? byp_free : (cur_free & below_cap);
    assign acc_write     = task_in_valid & task_in_ready & ~task_in.task_desc.no_write;
    assign acc_byp       = task_in_valid & task_in_ready & task_in.task_desc.no_write;

    assign finish_valid   = bvalid | byp_valid_q;
    assign finish_thread  = bvalid ? thread_id_t'(bid) : byp_thread_q;
    assign finish_cq_slot = bvalid ? slot_tbl[bid] : byp_slot_q;
    assign fin_hs         = finish_valid & finish_ready;

    assign reg_bus.rvalid = rvalid_q;
    assign reg_bus.rdata  = rdata_q;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({aw_hs, b_hs})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        case (reg_bus.araddr)
            DEBUG_CAPACITY:  rdata_d = 32'(outstanding_q);
            CORE_N_DEQUEUES: rdata_d = n_done_q;
            default:         rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_q          <= '0;
            cur_valid_q    <= 1'b0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            awaddr_q       <= '0;
            byp_valid_q    <= 1'b0;
            byp_thread_q   <= '0;
            byp_slot_q     <= '0;
            outstanding_q  <= '0;
            base_rw_addr_q <= '0;
            n_done_q       <= '0;
            rvalid_q       <= 1'b0;
            rdata_q        <= '0;
        end else begin
            if (acc_write) begin
                cur_q       <= task_in;
                cur_valid_q <= 1'b1;
                aw_done_q   <= 1'b0;
                w_done_q    <= 1'b0;
                // Address is frozen at accept so a base update cannot
                // disturb a pending AW.
                awaddr_q    <= base_rw_addr_q + (task_in.task_desc.locale << RW_ARSIZE);
            end else if (cur_drain) begin
                cur_valid_q <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end

            if (acc_byp) begin
                byp_valid_q  <= 1'b1;
                byp_thread_q <= task_in.thread;
                byp_slot_q   <= task_in.cq_slot;
            end else if (byp_drain) begin
                byp_valid_q <= 1'b0;
            end

            outstanding_q <= outstanding_d;
            if (fin_hs) n_done_q <= n_done_q + 32'd1;

            if (reg_bus.wvalid && reg_bus.waddr == RW_BASE_ADDR)
                base_rw_addr_q <= {reg_bus.wdata[29:0], 2'b00};
            rvalid_q <= reg_bus.arvalid;
            rdata_q  <= rdata_d;
        end
    end

    // Per-thread tables: one write port, asynchronous read of slot_tbl by bid.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            slot_tbl[cur_q.thread] <= cur_q.cq_slot;
            ts_tbl[cur_q.thread]   <= cur_q.task_desc.ts;
        end
    end

    // Fields carried along in the entry but not needed by this stage.
    logic unused_bits;
    assign unused_bits = ^{reg_bus.wdata[31:30], cur_q.task_desc.locale[31:4],
                           cur_q.task_desc.no_write, cur_q.cache_addr, ts_tbl[bid], TILE_ID};

endmodule

// File: tb/tb_write_rw.sv
module tb_write_rw;
   import swarm::*;

   logic           clk = 1'b0;
   logic           rstn;
   logic           task_in_valid;
   logic           task_in_ready;
   rw_write_t      task_in;
   logic           awvalid, awready;
   logic [31:0]    awaddr;
   id_t            awid;
   logic           wvalid, wready;
   logic [511:0]   wdata;
   logic [63:0]    wstrb;
   logic           bvalid, bready;
   id_t            bid;
   logic           finish_valid, finish_ready;
   thread_id_t     finish_thread;
   cq_slice_slot_t finish_cq_slot;

   reg_bus_t rb ();

   write_rw #(.TILE_ID(0)) dut (
      .clk(clk), .rstn(rstn),
      .task_in_valid(task_in_valid), .task_in_ready(task_in_ready), .task_in(task_in),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bid(bid),
      .finish_valid(finish_valid), .finish_ready(finish_ready),
      .finish_thread(finish_thread), .finish_cq_slot(finish_cq_slot),
      .reg_bus(rb)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input bit ok);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $error("FAIL %s", tag);
      end
   endtask

   logic [31:0]    m_base;
   logic [31:0]    m_done;
   int             m_out;
   cq_slice_slot_t m_slot [int];

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic rw_write_t mk(input logic [31:0] loc, input logic [31:0] obj,
                                    input thread_id_t th, input cq_slice_slot_t sl,
                                    input logic nw);
      rw_write_t e;
      e.task_desc.ts       = $urandom;
      e.task_desc.locale   = loc;
      e.task_desc.no_write = nw;
      e.cq_slot            = sl;
      e.thread             = th;
      e.object             = obj;
      e.cache_addr         = $urandom;
      return e;
   endfunction

   function automatic logic [31:0] exp_addr(input logic [31:0] loc);
      return m_base + loc * 32'd4;
   endfunction

   function automatic logic [63:0] exp_strb(input logic [31:0] loc);
      return 64'hF << (4 * (loc % 16));
   endfunction

   task automatic send(input rw_write_t e);
      int t;
      task_in       = e;
      task_in_valid = 1'b1;
      #1;
      t = 0;
      while (!task_in_ready && t < 50) begin
         step;
         t++;
      end
      chk("in_accept", task_in_ready === 1'b1);
      step;
      task_in_valid = 1'b0;
   endtask

   task automatic do_aw(input logic [31:0] ea, input thread_id_t eid, input int dly);
      int t;
      t = 0;
      while (!awvalid && t < 50) begin
         step;
         t++;
      end
      chk("aw_valid", awvalid === 1'b1);
      chk("awaddr", awaddr === ea);
      chk("awid", awid === eid);
      repeat (dly) begin
         step;
         chk("aw_hold", awvalid === 1'b1);
         chk("awaddr_stable", awaddr === ea);
      end
      awready = 1'b1;
      step;
      awready = 1'b0;
      m_out++;
   endtask

   task automatic do_w(input logic [63:0] es, input logic [31:0] obj, input int dly);
      int t;
      t = 0;
      while (!wvalid && t < 50) begin
         step;
         t++;
      end
      chk("w_valid", wvalid === 1'b1);
      chk("wstrb", wstrb === es);
      chk("wdata", wdata === {16{obj}});
      repeat (dly) begin
         step;
         chk("w_hold", wvalid === 1'b1);
      end
      wready = 1'b1;
      step;
      wready = 1'b0;
   endtask

   task automatic write_full(input rw_write_t e, input int aw_dly, input int w_dly, input int w_first);
      logic [31:0] ea;
      ea = exp_addr(e.task_desc.locale);
      send(e);
      if (w_first != 0) begin
         do_w(exp_strb(e.task_desc.locale), e.object, w_dly);
         do_aw(ea, e.thread, aw_dly);
      end else begin
         do_aw(ea, e.thread, aw_dly);
         do_w(exp_strb(e.task_desc.locale), e.object, w_dly);
      end
      m_slot[int'(e.thread)] = e.cq_slot;
   endtask

   task automatic do_b(input thread_id_t th, input int hold);
      bvalid       = 1'b1;
      bid          = th;
      finish_ready = 1'b0;
      #1;
      repeat (hold) begin
         chk("bready_low", bready === 1'b0);
         chk("fin_hold_valid", finish_valid === 1'b1);
         chk("fin_hold_thread", finish_thread === th);
         chk("fin_hold_slot", finish_cq_slot === m_slot[int'(th)]);
         step;
      end
      finish_ready = 1'b1;
      #1;
      chk("bready", bready === 1'b1);
      chk("fin_valid", finish_valid === 1'b1);
      chk("fin_thread", finish_thread === th);
      chk("fin_slot", finish_cq_slot === m_slot[int'(th)]);
      step;
      bvalid       = 1'b0;
      finish_ready = 1'b0;
      m_done++;
      m_out--;
   endtask

   task automatic bypass_one(input rw_write_t e, input int hold);
      send(e);
      chk("byp_valid", finish_valid === 1'b1);
      chk("byp_thread", finish_thread === e.thread);
      chk("byp_slot", finish_cq_slot === e.cq_slot);
      repeat (hold) begin
         step;
         chk("byp_hold", finish_valid === 1'b1);
         chk("byp_no_aw", awvalid === 1'b0);
      end
      finish_ready = 1'b1;
      step;
      finish_ready = 1'b0;
      m_done++;
      chk("byp_drained", finish_valid === 1'b0);
   endtask

   task automatic wr_base(input logic [31:0] d);
      rb.wvalid = 1'b1;
      rb.waddr  = RW_BASE_ADDR;
      rb.wdata  = d;
      step;
      rb.wvalid = 1'b0;
      m_base    = {d[29:0], 2'b00};
   endtask

   task automatic rd_chk(input logic [15:0] a, input logic [31:0] ev, input string tag);
      rb.arvalid = 1'b1;
      rb.araddr  = a;
      step;
      rb.arvalid = 1'b0;
      chk("rvalid", rb.rvalid === 1'b1);
      chk(tag, rb.rdata === ev);
      step;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rw_write_t e, f;
      rstn = 1'b0; task_in_valid = 1'b0; task_in = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; finish_ready = 1'b0;
      rb.wvalid = 1'b0; rb.waddr = '0; rb.wdata = '0; rb.arvalid = 1'b0; rb.araddr = '0;
      m_base = '0; m_done = '0; m_out = 0;
      repeat (3) step;
      chk("rst_awvalid", awvalid === 1'b0);
      chk("rst_wvalid", wvalid === 1'b0);
      chk("rst_finish", finish_valid === 1'b0);
      chk("rst_rvalid", rb.rvalid === 1'b0);
      rstn = 1'b1;
      step;
      rd_chk(DEBUG_CAPACITY, 32'd0, "cap_after_reset");

      wr_base(32'h0000_0400);
      e = mk(32'd5, 32'hDEAD_BEEF, 3'd3, 4'd7, 1'b0);
      send(e);
      chk("aw_latency", awvalid === 1'b1);
      chk("w_latency", wvalid === 1'b1);
      chk("awaddr_t1", awaddr === 32'h0000_1014);
      chk("wstrb_t1", wstrb === 64'h0000_0000_00F0_0000);
      do_aw(exp_addr(32'd5), 3'd3, 0);
      do_w(exp_strb(32'd5), 32'hDEAD_BEEF, 0);
      m_slot[3] = 4'd7;
      do_b(3'd3, 0);
      rd_chk(CORE_N_DEQUEUES, m_done, "ndeq_t1");

      e = mk($urandom, $urandom, 3'd1, 4'd2, 1'b0);
      f = mk($urandom, $urandom, 3'd6, 4'd12, 1'b0);
      send(e);
      task_in = f;
      task_in_valid = 1'b1;
      #1;
      chk("t2_ready_busy", task_in_ready === 1'b0);
      do_w(exp_strb(e.task_desc.locale), e.object, 0);
      repeat (3) begin
         #1;
         chk("t2_w_once", wvalid === 1'b0);
         chk("t2_aw_pend", awvalid === 1'b1);
         chk("t2_ready_wait", task_in_ready === 1'b0);
         step;
      end
      awready = 1'b1;
      #1;
      chk("t2_awaddr", awaddr === exp_addr(e.task_desc.locale));
      chk("t2_ready_now", task_in_ready === 1'b1);
      step;
      awready = 1'b0;
      task_in_valid = 1'b0;
      m_out++;
      m_slot[1] = 4'd2;
      do_aw(exp_addr(f.task_desc.locale), 3'd6, 0);
      do_w(exp_strb(f.task_desc.locale), f.object, 0);
      m_slot[6] = 4'd12;
      do_b(3'd1, 0);
      do_b(3'd6, 0);

      write_full(mk($urandom, $urandom, 3'd4, 4'd9, 1'b0), 0, 0, 0);
      bvalid = 1'b1; bid = 3'd4; finish_ready = 1'b1;
      task_in = mk($urandom, $urandom, 3'd2, 4'd5, 1'b1);
      task_in_valid = 1'b1;
      #1;
      chk("t3_ready", task_in_ready === 1'b1);
      chk("t3_b_first", finish_thread === 3'd4);
      chk("t3_b_slot", finish_cq_slot === 4'd9);
      step;
      bvalid = 1'b0; task_in_valid = 1'b0;
      m_done++; m_out--;
      #1;
      chk("t3_byp_valid", finish_valid === 1'b1);
      chk("t3_byp_thread", finish_thread === 3'd2);
      chk("t3_byp_slot", finish_cq_slot === 4'd5);
      chk("t3_no_aw", awvalid === 1'b0);
      chk("t3_no_w", wvalid === 1'b0);
      step;
      m_done++;
      chk("t3_byp_done", finish_valid === 1'b0);
      chk("t3_no_aw2", awvalid === 1'b0);
      finish_ready = 1'b0;

      write_full(mk($urandom, $urandom, 3'd0, 4'd11, 1'b0), 1, 2, 1);
      do_b(3'd0, 10);

      for (int b = 0; b < 12; b++) begin
         int k, j, tmp, off;
         int perm [8];
         for (int i = 0; i < 8; i++) perm[i] = i;
         for (int i = 7; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
         end
         if ($urandom_range(2, 0) == 0) wr_base($urandom);
         k = int'($urandom_range(4, 1));
         for (int i = 0; i < k; i++)
            write_full(mk($urandom, $urandom, thread_id_t'(perm[i]),
                          cq_slice_slot_t'($urandom_range(15, 0)), 1'b0),
                       int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                       int'($urandom_range(1, 0)));
         if ($urandom_range(1, 0) == 1)
            bypass_one(mk($urandom, $urandom, thread_id_t'($urandom_range(7, 0)),
                          cq_slice_slot_t'($urandom_range(15, 0)), 1'b1),
                       int'($urandom_range(2, 0)));
         off = int'($urandom_range(k - 1, 0));
         for (int i = 0; i < k; i++)
            do_b(thread_id_t'(perm[(i + off) % k]), int'($urandom_range(3, 0)));
      end
      rd_chk(CORE_N_DEQUEUES, m_done, "ndeq_random");
      rd_chk(DEBUG_CAPACITY, 32'(m_out), "cap_random");

      for (int i = 0; i < N_THREADS; i++)
         write_full(mk($urandom, $urandom, thread_id_t'(i), cq_slice_slot_t'(i + 1), 1'b0), 0, 0, 0);
      rd_chk(DEBUG_CAPACITY, 32'(N_THREADS), "cap_full");
      e = mk($urandom, $urandom, 3'd5, 4'd3, 1'b0);
      task_in = e;
      task_in_valid = 1'b1;
      repeat (3) begin
         #1;
         chk("full_ready_low", task_in_ready === 1'b0);
         step;
      end
      bvalid = 1'b1; bid = 3'd5; finish_ready = 1'b1;
      #1;
      chk("full_b_slot", finish_cq_slot === m_slot[5]);
      chk("full_ready_b_cycle", task_in_ready === 1'b0);
      step;
      bvalid = 1'b0; finish_ready = 1'b0;
      m_done++; m_out--;
      #1;
      chk("full_ready_after_b", task_in_ready === 1'b1);
      step;
      task_in_valid = 1'b0;
      do_aw(exp_addr(e.task_desc.locale), 3'd5, 0);
      do_w(exp_strb(e.task_desc.locale), e.object, 0);
      m_slot[5] = 4'd3;
      rd_chk(DEBUG_CAPACITY, 32'(m_out), "cap_refill");

      for (int i = 0; i < N_THREADS; i++)
         if (i != 2 && i != 5) do_b(thread_id_t'(i), 0);
      rd_chk(DEBUG_CAPACITY, 32'd2, "cap_two");
      send(mk($urandom, $urandom, 3'd1, 4'd4, 1'b0));
      send(mk($urandom, $urandom, 3'd0, 4'd6, 1'b1));
      chk("pre_rst_aw", awvalid === 1'b1);
      chk("pre_rst_fin", finish_valid === 1'b1);
      rb.arvalid = 1'b1;
      rb.araddr  = DEBUG_CAPACITY;
      rstn = 1'b0;
      step;
      rb.arvalid = 1'b0;
      chk("mid_rst_awvalid", awvalid === 1'b0);
      chk("mid_rst_wvalid", wvalid === 1'b0);
      chk("mid_rst_finish", finish_valid === 1'b0);
      chk("mid_rst_rvalid", rb.rvalid === 1'b0);
      rstn = 1'b1;
      m_base = '0; m_done = '0; m_out = 0;
      step;
      rd_chk(DEBUG_CAPACITY, 32'd0, "cap_post_rst");
      rd_chk(CORE_N_DEQUEUES, 32'd0, "ndeq_post_rst");

      write_full(mk($urandom, $urandom, 3'd2, 4'd13, 1'b0), 0, 1, 1);
      do_b(3'd2, 1);
      rd_chk(CORE_N_DEQUEUES, m_done, "ndeq_final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
